// File: rtl/computer_seq.sv
// computer_seq: instruction sequencer that fetches two operands, dispatches them
// to one of three external arithmetic units (CMP/ADD/SUB), waits for completion
// with a cycle budget, and returns the result over a valid/ready handshake.
//
// Ports:
//   clk, rst                   single clock, asynchronous active-high reset
//   i_ir_valid / o_ir_ready    instruction handshake, i_ir carries the opcode in its top nibble
//   i_data_valid, i_data       operand stream (first word -> op A, second -> op B)
//   o_unit_sel, o_unit_start   unit select (1=CMP, 2=ADD, 3=SUB) and one-cycle start pulse
//   o_op_a, o_op_b             operands presented to the selected unit
//   i_unit_done, i_unit_data   unit completion strobe and result
//   o_data, o_data_valid,
//   i_data_ready               result handshake toward the consumer
//   o_busy, o_err, o_instr_cnt status: busy, one-cycle error pulse, retired-instruction count
//
// Latency: accept in cycle 0, op A captured cycle 1, op B cycle 2, start cycle 3,
// earliest done cycle 4, result valid cycle 5. Backpressure: the result is held
// with o_data_valid high until i_data_ready; no new instruction is accepted meanwhile.

module computer_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_ir_valid,
  output logic                  o_ir_ready,
  input  logic [DATA_WIDTH-1:0] i_ir,

  input  logic                  i_data_valid,
  input  logic [DATA_WIDTH-1:0] i_data,

  output logic [1:0]            o_unit_sel,
  output logic                  o_unit_start,
  output logic [DATA_WIDTH-1:0] o_op_a,
  output logic [DATA_WIDTH-1:0] o_op_b,
  input  logic                  i_unit_done,
  input  logic [DATA_WIDTH-1:0] i_unit_data,

  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  input  logic                  i_data_ready,

  output logic                  o_busy,
  output logic                  o_err,
  output logic [7:0]            o_instr_cnt
);

  // Wait counter is at least 8 bits, and wide enough to hold TIMEOUT itself.
  localparam int TO_BITS = $clog2(TIMEOUT + 1);
  localparam int CW      = (TO_BITS > 8) ? TO_BITS : 8;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_CMP = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FETCH_B = 3'd2,
    ISSUE   = 3'd3,
    WAIT    = 3'd4,
    RESULT  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            sel_q, sel_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [CW-1:0]         wait_cnt_q, wait_cnt_d;

  logic [3:0] opcode;
  logic       timeout_hit;

  assign opcode = i_ir[DATA_WIDTH-1 -: 4];

  // Only the opcode nibble carries meaning; the remaining instruction bits are
  // reduced here so the intent of leaving them unused is explicit.
  logic unused_ir_bits;
  assign unused_ir_bits = ^i_ir[DATA_WIDTH-5:0];

  // The counter starts at 0 on the first WAIT cycle, so the TIMEOUT-th WAIT
  // cycle is the one where it reads TIMEOUT-1.
  assign timeout_hit = (wait_cnt_q == CW'(TIMEOUT - 1));

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= 2'd0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      cnt_q      <= 8'd0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      data_q     <= data_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    data_d     = data_q;
    err_d      = 1'b0;            // error is a single-cycle pulse
    cnt_d      = cnt_q;
    wait_cnt_d = wait_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (i_ir_valid) begin
          case (opcode)
            OP_NOP: begin
              // NOP retires immediately without touching any unit.
              cnt_d = cnt_q + 8'd1;
            end
            OP_CMP, OP_ADD, OP_SUB: begin
              sel_d   = opcode[1:0];
              state_d = FETCH_A;
            end
            default: begin
              // Illegal opcode: consumed, flagged, not counted.
              err_d = 1'b1;
            end
          endcase
        end
      end

      FETCH_A: begin
        if (i_data_valid) begin
          op_a_d  = i_data;
          state_d = FETCH_B;
        end
      end

      FETCH_B: begin
        if (i_data_valid) begin
          op_b_d  = i_data;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end

      WAIT: begin
        // A completion arriving on the expiry cycle still counts as success.
        if (i_unit_done) begin
          data_d  = i_unit_data;
          state_d = RESULT;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end

      RESULT: begin
        if (i_data_ready) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_ir_ready   = (state_q == IDLE);
  assign o_busy       = (state_q != IDLE);
  assign o_unit_start = (state_q == ISSUE);
  assign o_data_valid = (state_q == RESULT);
  assign o_unit_sel   = sel_q;
  assign o_op_a       = op_a_q;
  assign o_op_b       = op_b_q;
  assign o_data       = data_q;
  assign o_err        = err_q;
  assign o_instr_cnt  = cnt_q;

endmodule

// File: doc/computer_seq.md
COMPUTER_SEQ -- requirements
Module: computer_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the width of instruction, operand and result words.
REQ-002 Parameter TIMEOUT, default 64, SHALL set the maximum number of WAIT cycles allowed before a timeout.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 i_ir_valid  input  1  instruction offered; o_ir_ready  output  1  instruction accepted when both are high.
REQ-006 i_ir  input  DATA_WIDTH  instruction word; opcode = i_ir[DATA_WIDTH-1:DATA_WIDTH-4], other bits ignored.
REQ-007 i_data_valid  input  1, i_data  input  DATA_WIDTH  operand stream.
REQ-008 o_unit_sel  output  2  unit select (1=CMP, 2=ADD, 3=SUB); o_unit_start  output  1  one-cycle start pulse.
REQ-009 o_op_a, o_op_b  output  DATA_WIDTH  operands presented to the selected unit.
REQ-010 i_unit_done  input  1, i_unit_data  input  DATA_WIDTH  unit completion and result.
REQ-011 o_data  output  DATA_WIDTH, o_data_valid  output  1, i_data_ready  input  1  result handshake.
REQ-012 o_busy  output  1, o_err  output  1, o_instr_cnt  output  8  status.

Function
REQ-013 FSM states SHALL be IDLE, FETCH_A, FETCH_B, ISSUE, WAIT, RESULT.
REQ-014 o_ir_ready SHALL be 1 only in IDLE; o_busy SHALL be 1 in every state except IDLE.
REQ-015 IDLE, handshake, opcode 1/2/3: latch opcode into o_unit_sel, go to FETCH_A.
REQ-016 IDLE, handshake, opcode 0 (NOP): stay in IDLE, no start, no result, o_instr_cnt increments.
REQ-017 IDLE, handshake, opcode 4..15: o_err pulses high for exactly the next cycle, stay in IDLE, o_instr_cnt unchanged.
REQ-018 FETCH_A: first cycle with i_data_valid=1 captures i_data into o_op_a, go to FETCH_B; FETCH_B likewise into o_op_b, go to ISSUE; i_data_valid ignored in all other states.
REQ-019 ISSUE: o_unit_start=1 for exactly one cycle, go to WAIT; o_op_a/o_op_b/o_unit_sel held stable from ISSUE until leaving WAIT.
REQ-020 WAIT: 8-bit-or-wider cycle counter cleared on entry; i_unit_done=1 captures i_unit_data into o_data, go to RESULT.
REQ-021 WAIT: TIMEOUT consecutive WAIT cycles without i_unit_done -> IDLE, o_err pulses one cycle, no result, o_instr_cnt unchanged.
REQ-022 i_unit_done in the same cycle as timeout expiry: done wins, no error.
REQ-023 i_unit_done outside WAIT SHALL be ignored.
REQ-024 RESULT: o_data_valid=1, o_data stable until i_data_ready=1; on that cycle go to IDLE and increment o_instr_cnt.
REQ-025 Minimum latency with operands and done immediately available: IR accept cycle 0, o_op_a cycle 1, o_op_b cycle 2, start cycle 3, done cycle 4, o_data_valid cycle 5.
REQ-026 o_instr_cnt SHALL wrap 255 -> 0.

Reset
REQ-027 On rst: state IDLE; o_ir_ready=1 after release; o_busy, o_err, o_unit_start, o_data_valid = 0; o_unit_sel, o_op_a, o_op_b, o_data = 0; o_instr_cnt = 0; timeout counter = 0.
REQ-028 rst asserted mid-instruction SHALL discard it: no start, no result, no error, no counter update after release.

Verification
REQ-029 CMP: ir=0x1000, data 0x0005, 0x0003, done next cycle with 0x0001 -> start once, o_data=0x0001 valid cycle 5, o_instr_cnt=1.
REQ-030 Backpressure: ADD result 0x0008, i_data_ready low 4 cycles -> o_data_valid and o_data=0x0008 held 5 cycles, o_ir_ready low throughout.
REQ-031 Illegal: ir=0x7000 -> o_err high one cycle, no start, o_instr_cnt unchanged, next IR accepted.
REQ-032 Timeout: SUB issued, i_unit_done never -> o_err after 64 WAIT cycles, IDLE; same test with done on cycle 64 -> result, no error.
REQ-033 Reset in WAIT: rst pulse, then stray i_unit_done -> no o_data_valid, all outputs at reset values.
REQ-034 Wrap: 256 NOPs -> o_instr_cnt returns to 0, never o_busy.
